// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 4;
  localparam int WORD_BITS   = 32;
  localparam int BEAT_BITS   = $clog2(LINE_WORDS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;
endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-side bus of the instruction cache; the cache is the slave.
interface icache_if
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_rd;
  logic [DATA_WIDTH-1:0] cache_data;
  logic                  cache_waitrequest;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [WORD_BITS-1:0]  mem_rdata;
  logic                  mem_waitrequest;

  modport master (
    output cache_addr, cache_rd, flush, mem_rdata, mem_waitrequest,
    input  cache_data, cache_waitrequest, mem_addr, mem_rd
  );

  modport slave (
    input  cache_addr, cache_rd, flush, mem_rdata, mem_waitrequest,
    output cache_data, cache_waitrequest, mem_addr, mem_rd
  );
endinterface

// File: rtl/icache_data_array.sv
// Line storage: one asynchronous full-line read port, one 32-bit word write port.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int DATA_WIDTH = 128,
  localparam int INDEX_BITS = $clog2(NUM_LINES)
) (
  input  logic                  clock,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [BEAT_BITS-1:0]  wr_word,
  input  logic [WORD_BITS-1:0]  wr_data,
  input  logic                  wr_en
);
  logic [DATA_WIDTH-1:0] lines [NUM_LINES];

  assign rd_data = lines[rd_index];

  // NOTE: storage arrays carry no reset; validity is tracked separately, so a
  // reset here would only cost a wide reset network for no functional gain.
  // Word 0 of a line sits in the most significant slot.
  always_ff @(posedge clock) begin
    if (wr_en)
      lines[wr_index][(LINE_WORDS - 1 - int'(wr_word)) * WORD_BITS +: WORD_BITS] <= wr_data;
  end
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, 4-beat word refill FSM.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_LINES  = 64
) (
  input  logic    clock,
  input  logic    reset,
  icache_if.slave bus
);
  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

  icache_state_t         state_q;
  logic [BEAT_BITS-1:0]  beat_q;
  logic                  drop_q;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_BITS-1:0]   tag_q [NUM_LINES];
  logic [TAG_BITS-1:0]   fill_tag_q;
  logic [INDEX_BITS-1:0] fill_index_q;

  logic [INDEX_BITS-1:0] lu_index;
  logic [TAG_BITS-1:0]   lu_tag;
  logic                  hit;
  logic                  start_refill;
  logic                  beat_accept;
  logic                  last_beat;
  logic                  unused_offset;

  assign lu_index      = bus.cache_addr[OFFSET_BITS +: INDEX_BITS];
  assign lu_tag        = bus.cache_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign unused_offset = ^bus.cache_addr[OFFSET_BITS-1:0];

  assign hit = bus.cache_rd && (state_q == IDLE) && valid_q[lu_index]
               && (tag_q[lu_index] == lu_tag);
  assign bus.cache_waitrequest = bus.cache_rd && !hit;

  assign start_refill = (state_q == IDLE) && bus.cache_rd && !hit && !bus.flush;
  assign beat_accept  = (state_q == REFILL) && !bus.mem_waitrequest;
  assign last_beat    = beat_accept && (beat_q == BEAT_BITS'(LINE_WORDS - 1));

  assign bus.mem_rd   = (state_q == REFILL);
  assign bus.mem_addr = {fill_tag_q, fill_index_q, beat_q, 2'b00};

  icache_data_array #(
    .NUM_LINES (NUM_LINES),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_data (
    .clock   (clock),
    .rd_index(lu_index),
    .rd_data (bus.cache_data),
    .wr_index(fill_index_q),
    .wr_word (beat_q),
    .wr_data (bus.mem_rdata),
    .wr_en   (beat_accept)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drop_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_refill) begin
            state_q <= REFILL;
            beat_q  <= '0;
          end
        end
        REFILL: begin
          if (beat_accept) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              state_q <= IDLE;
              drop_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // A flush mid-refill lets the beats finish but keeps the line invalid.
      if (bus.flush) begin
        valid_q <= '0;
        if ((state_q == REFILL) && !last_beat)
          drop_q <= 1'b1;
      end else if (last_beat && !drop_q) begin
        valid_q[fill_index_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (start_refill) begin
      fill_tag_q   <= lu_tag;
      fill_index_q <= lu_index;
    end
    if (last_beat)
      tag_q[fill_index_q] <= fill_tag_q;
  end
endmodule
